counter_2to9_monitor: RTL and testbench

Passive checker for the 4-bit 2-to-9 up/down loadable counter. It sits beside the counter in the lab top level and samples the counter's controls (`en`, `load`, `data`, counter reset) and outputs (`dout`, `cout`). It predicts every next count and flags any mismatch. It also counts carry events for the display path.

---
 rtl/counter_mon_pkg.sv | 61 ++++++
 rtl/counter_2to9_ref_model.sv | 22 ++
 rtl/counter_2to9_monitor.sv | 155 +++++++++++++++
 tb/tb_counter_2to9_monitor.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_mon_pkg.sv
// Shared types, constants and count arithmetic for the 2-to-9 counter monitor.
// The FAULT state exists only when COUNTER_MON_STICKY_EN is defined.
package counter_mon_pkg;

    localparam int CNT_W = 4;

    typedef logic [CNT_W-1:0] count_t;

    localparam count_t CNT_LO = 4'd2;
    localparam count_t CNT_HI = 4'd9;

    typedef enum logic [1:0] {
        ST_UNSYNC = 2'd0,
        ST_TRACK  = 2'd1
`ifdef COUNTER_MON_STICKY_EN
        ,
        ST_FAULT  = 2'd2
`endif
    } mon_state_e;

    function automatic logic in_range(
        input count_t v,
        input count_t lo,
        input count_t hi
    );
        return (v >= lo) && (v <= hi);
    endfunction

    // Counter reset beats load, load beats counting; counting wraps inside lo..hi.
    function automatic count_t next_count(
        input count_t cur,
        input logic   rst,
        input logic   load,
        input count_t data,
        input logic   en,
        input count_t lo = CNT_LO,
        input count_t hi = CNT_HI
    );
        count_t nxt;
        if (rst) begin
            nxt = lo;
        end else if (load) begin
            nxt = data;
        end else if (en) begin
            nxt = (cur == hi) ? lo : count_t'(cur + 1'b1);
        end else begin
            nxt = (cur == lo) ? hi : count_t'(cur - 1'b1);
        end
        return nxt;
    endfunction

    function automatic logic carry_of(
        input count_t dout,
        input logic   en,
        input count_t lo,
        input count_t hi
    );
        return ((dout == hi) && en) || ((dout == lo) && !en);
    endfunction

endpackage

// File: rtl/counter_2to9_ref_model.sv
// Combinational golden model of the 2-to-9 up/down loadable counter:
// next count from a chosen current value, and the carry implied by dout.
module counter_2to9_ref_model
    import counter_mon_pkg::*;
#(
    parameter count_t LO = CNT_LO,
    parameter count_t HI = CNT_HI
) (
    input  logic   [CNT_W-1:0] cur_i,
    input  logic               cnt_rst_i,
    input  logic               load_i,
    input  logic   [CNT_W-1:0] data_i,
    input  logic               en_i,
    input  logic   [CNT_W-1:0] dout_i,
    output logic   [CNT_W-1:0] next_o,
    output logic               cout_o
);

    assign next_o = next_count(cur_i, cnt_rst_i, load_i, data_i, en_i, LO, HI);
    assign cout_o = carry_of(dout_i, en_i, LO, HI);

endmodule

// File: rtl/counter_2to9_monitor.sv
// Passive checker for the 2-to-9 up/down counter: predicts each count, flags
// mismatches and counts carry events. COUNTER_MON_STICKY_EN adds a sticky FAULT state.
module counter_2to9_monitor
    import counter_mon_pkg::*;
#(
    parameter count_t LO     = CNT_LO,
    parameter count_t HI     = CNT_HI,
    parameter int     ERR_W  = 8,
    parameter int     WRAP_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cnt_rst_i,
    input  logic              en_i,
    input  logic              load_i,
    input  logic [CNT_W-1:0]  data_i,
    input  logic [CNT_W-1:0]  dout_i,
    input  logic              cout_i,
    output logic              synced_o,
    output logic              err_o,
    output logic [ERR_W-1:0]  err_cnt_o,
    output logic [WRAP_W-1:0] wrap_cnt_o
`ifdef COUNTER_MON_STICKY_EN
    ,
    output logic              fault_o,
    output logic [CNT_W-1:0]  bad_val_o
`endif
);

    mon_state_e        state_q;
    count_t            exp_q;
    count_t            exp_d;
    count_t            cur_sel;
    logic              exp_cout;
    logic              synced_q;
    logic              err_q;
    logic [ERR_W-1:0]  err_cnt_q;
    logic [WRAP_W-1:0] wrap_cnt_q;
`ifdef COUNTER_MON_STICKY_EN
    logic              fault_q;
    count_t            bad_val_q;
`else
    logic              dout_legal;
`endif

    logic load_legal;
    logic sync_evt;
    logic bad_load;
    logic carry_chk;
    logic mismatch;
    logic carry_evt;

    // A value mismatch means we resync from dout; otherwise dout equals exp anyway,
    // so one model instance serves both the normal advance and the resync.
    assign cur_sel    = (dout_i != exp_q) ? dout_i : exp_q;

    assign load_legal = in_range(data_i, LO, HI);
    assign sync_evt   = cnt_rst_i || (load_i && load_legal);
    assign bad_load   = load_i && !cnt_rst_i && !load_legal;
    assign carry_chk  = !cnt_rst_i && !load_i;
    assign mismatch   = (dout_i != exp_q) || (carry_chk && (cout_i != exp_cout));
    assign carry_evt  = carry_chk && cout_i && exp_cout;
`ifndef COUNTER_MON_STICKY_EN
    assign dout_legal = in_range(dout_i, LO, HI);
`endif

    counter_2to9_ref_model #(
        .LO (LO),
        .HI (HI)
    ) u_ref (
        .cur_i     (cur_sel),
        .cnt_rst_i (cnt_rst_i),
        .load_i    (load_i),
        .data_i    (data_i),
        .en_i      (en_i),
        .dout_i    (dout_i),
        .next_o    (exp_d),
        .cout_o    (exp_cout)
    );

    // Monitor FSM; all outputs are registered here. err defaults low so it pulses.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_UNSYNC;
            exp_q      <= LO;
            synced_q   <= 1'b0;
            err_q      <= 1'b0;
            err_cnt_q  <= '0;
            wrap_cnt_q <= '0;
`ifdef COUNTER_MON_STICKY_EN
            fault_q    <= 1'b0;
            bad_val_q  <= '0;
`endif
        end else begin
            err_q <= 1'b0;
            case (state_q)
                ST_UNSYNC: begin
                    if (sync_evt) begin
                        state_q  <= ST_TRACK;
                        exp_q    <= exp_d;
                        synced_q <= 1'b1;
                    end
                end
                ST_TRACK: begin
                    if (bad_load) begin
                        // The counter now holds an illegal value; stop predicting quietly.
                        state_q  <= ST_UNSYNC;
                        synced_q <= 1'b0;
                    end else if (!mismatch) begin
                        exp_q <= exp_d;
                        if (carry_evt) begin
                            wrap_cnt_q <= wrap_cnt_q + 1'b1;
                        end
                    end else begin
                        err_q <= 1'b1;
                        if (err_cnt_q != '1) begin
                            err_cnt_q <= err_cnt_q + 1'b1;
                        end
`ifdef COUNTER_MON_STICKY_EN
                        state_q   <= ST_FAULT;
                        synced_q  <= 1'b0;
                        fault_q   <= 1'b1;
                        bad_val_q <= dout_i;
`else
                        if (dout_legal) begin
                            exp_q <= exp_d;
                        end else begin
                            state_q  <= ST_UNSYNC;
                            synced_q <= 1'b0;
                        end
`endif
                    end
                end
`ifdef COUNTER_MON_STICKY_EN
                ST_FAULT: begin
                end
`endif
                default: begin
                    state_q  <= ST_UNSYNC;
                    synced_q <= 1'b0;
                end
            endcase
        end
    end

    assign synced_o   = synced_q;
    assign err_o      = err_q;
    assign err_cnt_o  = err_cnt_q;
    assign wrap_cnt_o = wrap_cnt_q;
`ifdef COUNTER_MON_STICKY_EN
    assign fault_o    = fault_q;
    assign bad_val_o  = bad_val_q;
`endif

endmodule

// File: tb/tb_counter_2to9_monitor.sv
// Directed plus randomized bench for counter_2to9_monitor against a behavioural model.
// Handles both builds, with and without COUNTER_MON_STICKY_EN.
module tb_counter_2to9_monitor;

    localparam int LO   = 2;
    localparam int HI   = 9;
    localparam int SPAN = HI - LO + 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       cnt_rst;
    logic       en;
    logic       load;
    logic [3:0] data;
    logic [3:0] dout;
    logic       cout;
    logic       synced;
    logic       err;
    logic [7:0] err_cnt;
    logic [7:0] wrap_cnt;
`ifdef COUNTER_MON_STICKY_EN
    logic       fault;
    logic [3:0] bad_val;
`endif

    int nAssert = 0;
    int nFail   = 0;

    bit mSynced, mErr, mFault;
    int mExp, mErrCnt, mWrap, mBadVal;
    int cntVal;

    always #5 clk = ~clk;

    counter_2to9_monitor dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .cnt_rst_i  (cnt_rst),
        .en_i       (en),
        .load_i     (load),
        .data_i     (data),
        .dout_i     (dout),
        .cout_i     (cout),
        .synced_o   (synced),
        .err_o      (err),
        .err_cnt_o  (err_cnt),
        .wrap_cnt_o (wrap_cnt)
`ifdef COUNTER_MON_STICKY_EN
        ,
        .fault_o    (fault),
        .bad_val_o  (bad_val)
`endif
    );

    function automatic bit inRange(int v);
        return (v >= LO) && (v <= HI);
    endfunction

    // Counting is a walk around a ring of SPAN values starting at LO.
    function automatic int stepVal(int cur, bit up);
        if (up) return LO + ((cur - LO + 1) % SPAN);
        return LO + ((cur - LO + SPAN - 1) % SPAN);
    endfunction

    function automatic int refNext(int cur, bit cr, bit ld, int dt, bit e);
        if (cr) return LO;
        if (ld) return dt;
        return stepVal(cur, e);
    endfunction

    function automatic bit carryOf(int v, bit e);
        return (v == HI && e) || (v == LO && !e);
    endfunction

    function automatic int counterNext(int cur, bit cr, bit ld, int dt, bit e);
        if (cr) return LO;
        if (ld) return dt;
        if (!inRange(cur)) return LO;
        return stepVal(cur, e);
    endfunction

    task automatic modelEdge(bit r, bit cr, bit ld, int dt, bit e, int dv, bit co);
        bit chk, bad;
        if (r) begin
            mSynced = 0; mErr = 0; mFault = 0; mBadVal = 0;
            mErrCnt = 0; mWrap = 0; mExp = LO;
            return;
        end
        mErr = 0;
        if (mFault) return;
        if (!mSynced) begin
            if (cr || (ld && inRange(dt))) begin
                mSynced = 1;
                mExp    = refNext(mExp, cr, ld, dt, e);
            end
            return;
        end
        if (ld && !cr && !inRange(dt)) begin
            mSynced = 0;
            return;
        end
        chk = !cr && !ld;
        bad = (dv != mExp) || (chk && (co != carryOf(dv, e)));
        if (!bad) begin
            if (chk && co) mWrap = (mWrap + 1) % 256;
            mExp = refNext(mExp, cr, ld, dt, e);
        end else begin
            mErr = 1;
            if (mErrCnt < 255) mErrCnt++;
`ifdef COUNTER_MON_STICKY_EN
            mFault  = 1;
            mBadVal = dv;
            mSynced = 0;
`else
            if (inRange(dv)) mExp = refNext(dv, cr, ld, dt, e);
            else mSynced = 0;
`endif
        end
    endtask

    task automatic checkOutput(string tag);
        nAssert++;
        assert (synced === mSynced) else begin
            nFail++;
            $error("[TB] FAIL %s synced observed=%0b expected=%0b", tag, synced, mSynced);
        end
        nAssert++;
        assert (err === mErr) else begin
            nFail++;
            $error("[TB] FAIL %s err observed=%0b expected=%0b", tag, err, mErr);
        end
        nAssert++;
        assert (err_cnt === 8'(mErrCnt)) else begin
            nFail++;
            $error("[TB] FAIL %s err_cnt observed=%0d expected=%0d", tag, err_cnt, mErrCnt);
        end
        nAssert++;
        assert (wrap_cnt === 8'(mWrap)) else begin
            nFail++;
            $error("[TB] FAIL %s wrap_cnt observed=%0d expected=%0d", tag, wrap_cnt, mWrap);
        end
`ifdef COUNTER_MON_STICKY_EN
        nAssert++;
        assert (fault === mFault) else begin
            nFail++;
            $error("[TB] FAIL %s fault observed=%0b expected=%0b", tag, fault, mFault);
        end
        nAssert++;
        assert (bad_val === 4'(mBadVal)) else begin
            nFail++;
            $error("[TB] FAIL %s bad_val observed=%0d expected=%0d", tag, bad_val, mBadVal);
        end
`endif
    endtask

    task automatic applyStimulus(bit r, bit cr, bit ld, int dt, bit e, int dv, bit co, string tag);
        @(negedge clk);
        rst = r; cnt_rst = cr; load = ld; data = 4'(dt); en = e; dout = 4'(dv); cout = co;
        @(posedge clk);
        modelEdge(r, cr, ld, dt, e, dv, co);
        #1;
        checkOutput(tag);
    endtask

    task automatic counterStep(bit cr, bit ld, int dt, bit e, string tag);
        applyStimulus(0, cr, ld, dt, e, cntVal, carryOf(cntVal, e), tag);
        cntVal = counterNext(cntVal, cr, ld, dt, e);
    endtask

    task automatic checkValue(string tag, int observed, int expected);
        nAssert++;
        assert (observed === expected) else begin
            nFail++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    initial begin
        bit r, cr, ld, e, co;
        int dt, dv;
        rst = 1; cnt_rst = 0; load = 0; data = 0; en = 1; dout = 0; cout = 0;
        cntVal = 0;
        mExp = LO;

        applyStimulus(1, 0, 0, 0, 1, 0, 0, "reset");
        counterStep(1, 0, 0, 1, "cnt_rst_sync");
        repeat (20) counterStep(0, 0, 0, 1, "count_up");
        checkValue("wrap_after_20", int'(wrap_cnt), 2);
        checkValue("err_after_20", int'(err_cnt), 0);

        counterStep(0, 1, 5, 0, "load5");
        repeat (5) counterStep(0, 0, 0, 0, "count_down");
        checkValue("wrap_after_down", int'(wrap_cnt), 3);

        counterStep(1, 0, 0, 1, "cnt_rst_again");
        repeat (5) counterStep(0, 0, 0, 1, "up_to_6");
        applyStimulus(0, 0, 0, 0, 1, 8, 0, "skip_6_to_8");
        checkValue("skip_err", int'(err), 1);
        checkValue("skip_err_cnt", int'(err_cnt), 1);
        cntVal = 9;
        counterStep(0, 0, 0, 1, "after_skip");

        applyStimulus(1, 0, 0, 0, 1, 15, 1, "rst_with_mismatch");
        checkValue("rst_no_err", int'(err), 0);
        counterStep(1, 1, 7, 1, "cnt_rst_and_load");
        counterStep(0, 0, 0, 1, "expect_2");
        checkValue("rst_load_no_err", int'(err), 0);

        counterStep(0, 1, 12, 1, "load_illegal");
        checkValue("illegal_unsynced", int'(synced), 0);
        counterStep(1, 0, 0, 1, "resync");

`ifndef COUNTER_MON_STICKY_EN
        repeat (300) begin
            dv = (mExp == LO) ? LO + 1 : LO;
            applyStimulus(0, 0, 0, 0, 1, dv, carryOf(dv, 1), "force_mismatch");
        end
        checkValue("err_cnt_saturated", int'(err_cnt), 255);
        checkValue("err_pulse_saturated", int'(err), 1);
        counterStep(1, 0, 0, 1, "resync_after_sat");
`endif

        // Randomized traffic: a mostly-correct counter with occasional corruption.
        repeat (400) begin
            r  = ($urandom % 64) == 0;
            cr = ($urandom % 16) == 0;
            ld = ($urandom % 10) == 0;
            dt = $urandom % 16;
            e  = $urandom % 2;
            if (($urandom % 12) == 0) begin
                dv = $urandom % 16;
                co = $urandom % 2;
            end else begin
                dv = cntVal;
                co = carryOf(cntVal, e);
            end
            applyStimulus(r, cr, ld, dt, e, dv, co, "random");
            cntVal = counterNext(dv, cr, ld, dt, e);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
